// File: rtl/dsp48a1_mac_pkg.sv
// rtl/dsp48a1_mac_pkg.sv - shared types, OPMODE constants and tag decode for the DSP48A1 MAC sequencer
package dsp48a1_mac_pkg;

    typedef enum logic [2:0] {
        INIT,
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    localparam logic [7:0] OPM_LOAD_M     = 8'b0000_0001; // P = M
    localparam logic [7:0] OPM_ACC_M      = 8'b0000_1001; // P = P + M
    localparam logic [7:0] OPM_HOLD       = 8'b0000_1000; // P = P
    localparam logic [7:0] OPM_PREADD_BIT = 8'b0001_0000; // B path through the pre-adder

    typedef struct packed {
        logic v;
        logic first;
    } tag_t;

    function automatic logic [7:0] tag_to_opmode(input tag_t tag, input logic preadd);
        logic [7:0] opm;
        if (!tag.v) begin
            opm = OPM_HOLD;
        end else begin
            opm = tag.first ? OPM_LOAD_M : OPM_ACC_M;
            if (preadd) begin
                opm = opm | OPM_PREADD_BIT;
            end
        end
        return opm;
    endfunction

endpackage

// File: rtl/dsp48a1_tag_pipe.sv
// rtl/dsp48a1_tag_pipe.sv - delays operand tags to line them up with the slice OPMODE register
//
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   tag_in      tag pushed every cycle ({v, first}; v=0 is a bubble)
//   opmode      decoded OPMODE, registered, DEPTH cycles after tag_in
//
// DEPTH must be >= 2: DEPTH-1 tag stages followed by the registered decode,
// so the output resets to 0 rather than to the HOLD encoding.
module dsp48a1_tag_pipe
    import dsp48a1_mac_pkg::*;
#(
    parameter int DEPTH  = 2,
    parameter bit PREADD = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  tag_t       tag_in,
    output logic [7:0] opmode
);

    tag_t stage [DEPTH-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                stage[i] <= '0;
            end
            opmode <= '0;
        end else begin
            stage[0] <= tag_in;
            for (int i = 1; i < DEPTH - 1; i++) begin
                stage[i] <= stage[i-1];
            end
            opmode <= tag_to_opmode(stage[DEPTH-2], PREADD);
        end
    end

endmodule

// File: rtl/dsp48a1_mac_sequencer.sv
// rtl/dsp48a1_mac_sequencer.sv - drives one DSP48A1 slice as a streaming dot-product engine
//
// Ports:
//   CLK, RST_N                      clock, asynchronous active-low reset
//   job_valid/job_ready/job_len     job descriptor handshake (job_len = number of pairs)
//   in_valid/in_ready/in_a/in_b/in_d operand pair stream
//   res_valid/res_ready/res_data/res_carry  result handshake
//   dsp_a/b/d/c, dsp_carryin, dsp_opmode, dsp_rst  slice inputs
//   dsp_p, dsp_carryout             slice outputs
//
// Build option: define MAC_PREADD_EN to form each term as (in_d + in_b) * in_a;
// otherwise in_d is ignored and dsp_d stays 0.
module dsp48a1_mac_sequencer
    import dsp48a1_mac_pkg::*;
#(
    parameter int LEN_W   = 10,
    parameter int DSP_LAT = 3,
    parameter int OPM_LAT = 1
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             job_valid,
    output logic             job_ready,
    input  logic [LEN_W-1:0] job_len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [17:0]      in_a,
    input  logic [17:0]      in_b,
    input  logic [17:0]      in_d,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [47:0]      res_data,
    output logic             res_carry,
    output logic [17:0]      dsp_a,
    output logic [17:0]      dsp_b,
    output logic [17:0]      dsp_d,
    output logic [47:0]      dsp_c,
    output logic             dsp_carryin,
    output logic [7:0]       dsp_opmode,
    output logic             dsp_rst,
    input  logic [47:0]      dsp_p,
    input  logic             dsp_carryout
);

`ifdef MAC_PREADD_EN
    localparam bit PREADD = 1'b1;
`else
    localparam bit PREADD = 1'b0;
`endif
    localparam logic [17:0] D_MASK = PREADD ? 18'h3FFFF : 18'h00000;
    localparam int          TMR_W  = $clog2(DSP_LAT + 1) + 1;

    state_t             state;
    logic [LEN_W-1:0]   len;
    logic [LEN_W-1:0]   count;
    logic [TMR_W-1:0]   tmr;     // INIT reset stretch, then DRAIN down-counter
    logic               accept;
    tag_t               tag_in;

    assign dsp_c       = '0;
    assign dsp_carryin = 1'b0;

    // in_ready is only ever high in RUN, so this also gates in_valid outside RUN.
    assign accept = in_valid & in_ready;

    always_comb begin
        tag_in.v     = accept;
        tag_in.first = accept && (count == '0);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state     <= INIT;
            job_ready <= 1'b0;
            in_ready  <= 1'b0;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_carry <= 1'b0;
            dsp_a     <= '0;
            dsp_b     <= '0;
            dsp_d     <= '0;
            dsp_rst   <= 1'b1;
            len       <= '0;
            count     <= '0;
            tmr       <= '0;
        end else begin
            if (accept) begin
                dsp_a <= in_a;
                dsp_b <= in_b;
                dsp_d <= in_d & D_MASK;
            end
            case (state)
                INIT: begin
                    if (tmr == TMR_W'(DSP_LAT - 1)) begin
                        state     <= IDLE;
                        dsp_rst   <= 1'b0;
                        job_ready <= 1'b1;
                        tmr       <= '0;
                    end else begin
                        tmr <= tmr + TMR_W'(1);
                    end
                end
                IDLE: begin
                    if (job_valid) begin
                        job_ready <= 1'b0;
                        if (job_len == '0) begin
                            // Empty job: answer immediately without touching the slice.
                            res_data  <= '0;
                            res_carry <= 1'b0;
                            res_valid <= 1'b1;
                            state     <= DONE;
                        end else begin
                            len      <= job_len;
                            count    <= '0;
                            in_ready <= 1'b1;
                            state    <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (accept) begin
                        count <= count + LEN_W'(1);
                        if (count == len - LEN_W'(1)) begin
                            in_ready <= 1'b0;
                            tmr      <= TMR_W'(DSP_LAT);
                            state    <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    // DSP_LAT+1 cycles: the last term lands in P after DSP_LAT
                    // edges, and it is sampled on the edge after that.
                    if (tmr == '0) begin
                        res_data  <= dsp_p;
                        res_carry <= dsp_carryout;
                        res_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        tmr <= tmr - TMR_W'(1);
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        job_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state   <= INIT;
                    dsp_rst <= 1'b1;
                    tmr     <= '0;
                end
            endcase
        end
    end

    dsp48a1_tag_pipe #(
        .DEPTH  (DSP_LAT - OPM_LAT),
        .PREADD (PREADD)
    ) u_tag_pipe (
        .clk    (CLK),
        .rst_n  (RST_N),
        .tag_in (tag_in),
        .opmode (dsp_opmode)
    );

endmodule

// File: tb/tb_dsp48a1_mac_sequencer.sv
// tb/tb_dsp48a1_mac_sequencer.sv - scoreboard bench for dsp48a1_mac_sequencer with a behavioural DSP48A1 slice
module tb_dsp48a1_mac_sequencer;

`ifdef MAC_PREADD_EN
    localparam logic [17:0] D_GARB   = 18'd0;
    localparam logic [7:0]  OPM_LD_X = 8'h11;
    localparam logic [7:0]  OPM_AC_X = 8'h19;
    localparam logic [47:0] PRE_RES  = 48'd700;
    localparam logic [17:0] LAST_D   = 18'd25;
`else
    localparam logic [17:0] D_GARB   = 18'd7;
    localparam logic [7:0]  OPM_LD_X = 8'h01;
    localparam logic [7:0]  OPM_AC_X = 8'h09;
    localparam logic [47:0] PRE_RES  = 48'd200;
    localparam logic [17:0] LAST_D   = 18'd0;
`endif

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        job_valid, job_ready;
    logic [9:0]  job_len;
    logic        in_valid, in_ready;
    logic [17:0] in_a, in_b, in_d;
    logic        res_valid, res_ready;
    logic [47:0] res_data;
    logic        res_carry;
    logic [17:0] dsp_a, dsp_b, dsp_d;
    logic [47:0] dsp_c;
    logic        dsp_carryin;
    logic [7:0]  dsp_opmode;
    logic        dsp_rst;
    logic [47:0] dsp_p;
    logic        dsp_carryout;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [47:0] data;
        logic        carry;
    } exp_t;
    exp_t exp_q[$];

    always #5 CLK = ~CLK;

    dsp48a1_mac_sequencer dut (
        .CLK          (CLK),
        .RST_N        (RST_N),
        .job_valid    (job_valid),
        .job_ready    (job_ready),
        .job_len      (job_len),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_a         (in_a),
        .in_b         (in_b),
        .in_d         (in_d),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .res_data     (res_data),
        .res_carry    (res_carry),
        .dsp_a        (dsp_a),
        .dsp_b        (dsp_b),
        .dsp_d        (dsp_d),
        .dsp_c        (dsp_c),
        .dsp_carryin  (dsp_carryin),
        .dsp_opmode   (dsp_opmode),
        .dsp_rst      (dsp_rst),
        .dsp_p        (dsp_p),
        .dsp_carryout (dsp_carryout)
    );

    // Slice model: A1/B1/D1 -> M -> P, OPMODE register one stage ahead of P.
    logic [17:0] a1, b1, d1;
    logic [35:0] m_q;
    logic [7:0]  opm_r;
    logic [47:0] x_sel, z_sel;

    always_comb begin
        x_sel = (opm_r[1:0] == 2'b01) ? {{12{m_q[35]}}, m_q} : 48'd0;
        z_sel = (opm_r[3:2] == 2'b10) ? dsp_p : 48'd0;
    end

    always @(posedge CLK) begin
        if (dsp_rst) begin
            a1 <= '0; b1 <= '0; d1 <= '0; m_q <= '0; opm_r <= '0;
            dsp_p <= '0; dsp_carryout <= 1'b0;
        end else begin
            a1    <= dsp_a;
            b1    <= dsp_b;
            d1    <= dsp_d;
            opm_r <= dsp_opmode;
`ifdef MAC_PREADD_EN
            m_q <= 36'($signed(a1) * ($signed(d1) + $signed(b1)));
`else
            m_q <= 36'($signed(a1) * $signed(b1));
`endif
            {dsp_carryout, dsp_p} <= {1'b0, z_sel} + {1'b0, x_sel};
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: compare each handed-over result against the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            if (RST_N && res_valid && res_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_result", {16'd0, res_data}, 64'hDEAD);
                end else begin
                    e = exp_q.pop_front();
                    check("res_data", {16'd0, res_data}, {16'd0, e.data});
                    check("res_carry", {63'd0, res_carry}, {63'd0, e.carry});
                end
            end
        end
    end

    task automatic push_exp(input logic [47:0] data, input logic carry);
        exp_t e;
        e.data  = data;
        e.carry = carry;
        exp_q.push_back(e);
    endtask

    task automatic issue_job(input logic [9:0] len);
        bit ok = 1'b0;
        job_len = len;
        for (int i = 0; i < 30; i++) begin
            if (job_ready) begin
                job_valid = 1'b1;
                @(posedge CLK); #1;
                job_valid = 1'b0;
                ok = 1'b1;
                break;
            end
            @(posedge CLK); #1;
        end
        check("job_accept", {63'd0, ok}, 64'd1);
    endtask

    task automatic send_pair(input logic [17:0] a, input logic [17:0] b, input logic [17:0] d);
        bit ok = 1'b0;
        in_a = a; in_b = b; in_d = d;
        in_valid = 1'b1;
        for (int i = 0; i < 30; i++) begin
            if (in_ready) begin
                @(posedge CLK); #1;
                ok = 1'b1;
                break;
            end
            @(posedge CLK); #1;
        end
        check("pair_accept", {63'd0, ok}, 64'd1);
    endtask

    task automatic wait_drain();
        bit ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge CLK);
            if (exp_q.size() == 0 && job_ready) begin
                ok = 1'b1;
                break;
            end
        end
        check("job_done", {63'd0, ok}, 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        RST_N = 1'b0; job_valid = 1'b0; job_len = '0;
        in_valid = 1'b0; in_a = '0; in_b = '0; in_d = '0; res_ready = 1'b1;

        // Reset state
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("rst_job_ready", {63'd0, job_ready}, 64'd0);
        check("rst_in_ready", {63'd0, in_ready}, 64'd0);
        check("rst_res_valid", {63'd0, res_valid}, 64'd0);
        check("rst_res_data", {16'd0, res_data}, 64'd0);
        check("rst_res_carry", {63'd0, res_carry}, 64'd0);
        check("rst_dsp_ab", {28'd0, dsp_a, dsp_b}, 64'd0);
        check("rst_dsp_d", {46'd0, dsp_d}, 64'd0);
        check("rst_dsp_c", {16'd0, dsp_c}, 64'd0);
        check("rst_opmode", {56'd0, dsp_opmode}, 64'd0);
        check("rst_dsp_rst", {63'd0, dsp_rst}, 64'd1);
        @(posedge CLK); #1;
        RST_N = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            check("init_dsp_rst", {63'd0, dsp_rst}, 64'd1);
            check("init_job_ready", {63'd0, job_ready}, 64'd0);
        end
        @(negedge CLK);
        check("idle_job_ready", {63'd0, job_ready}, 64'd1);
        check("idle_dsp_rst", {63'd0, dsp_rst}, 64'd0);

        // Back-to-back stream: 1*2+3*4+5*6+7*8 = 100
        issue_job(10'd4);
        push_exp(48'd100, 1'b0);
        send_pair(18'd1, 18'd2, D_GARB);
        send_pair(18'd3, 18'd4, D_GARB);
        send_pair(18'd5, 18'd6, D_GARB);
        send_pair(18'd7, 18'd8, D_GARB);
        in_valid = 1'b0;
        wait_drain();

        // Two bubbles between pairs 2 and 3
        issue_job(10'd4);
        push_exp(48'd100, 1'b0);
        send_pair(18'd1, 18'd2, D_GARB);
        send_pair(18'd3, 18'd4, D_GARB);
        in_valid = 1'b0;
        @(negedge CLK);
        check("opm_load", {56'd0, dsp_opmode}, {56'd0, OPM_LD_X});
        @(negedge CLK);
        check("opm_acc", {56'd0, dsp_opmode}, {56'd0, OPM_AC_X});
        @(negedge CLK);
        check("opm_bubble1", {56'd0, dsp_opmode}, 64'h08);
        send_pair(18'd5, 18'd6, D_GARB);
        @(negedge CLK);
        check("opm_bubble2", {56'd0, dsp_opmode}, 64'h08);
        send_pair(18'd7, 18'd8, D_GARB);
        in_valid = 1'b0;
        wait_drain();

        // Wrap and carry: (-1)*1 + (-1)*1, then a carry-free job
        issue_job(10'd2);
        push_exp(48'hFFFF_FFFF_FFFE, 1'b1);
        send_pair(18'h3FFFF, 18'd1, D_GARB);
        send_pair(18'h3FFFF, 18'd1, D_GARB);
        in_valid = 1'b0;
        wait_drain();
        issue_job(10'd1);
        push_exp(48'd12, 1'b0);
        send_pair(18'd3, 18'd4, D_GARB);
        in_valid = 1'b0;
        wait_drain();

        // Zero-length job under backpressure
        res_ready = 1'b0;
        issue_job(10'd0);
        push_exp(48'd0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            check("bp_res_valid", {63'd0, res_valid}, 64'd1);
            check("bp_res_data", {16'd0, res_data}, 64'd0);
            check("bp_job_ready", {63'd0, job_ready}, 64'd0);
        end
        @(posedge CLK); #1;
        res_ready = 1'b1;
        wait_drain();

        // Reset in the middle of a job
        issue_job(10'd4);
        send_pair(18'd1, 18'd2, D_GARB);
        send_pair(18'd3, 18'd4, D_GARB);
        in_valid = 1'b0;
        RST_N = 1'b0;
        @(negedge CLK);
        check("mid_rst_dsp_rst", {63'd0, dsp_rst}, 64'd1);
        check("mid_rst_in_ready", {63'd0, in_ready}, 64'd0);
        check("mid_rst_opmode", {56'd0, dsp_opmode}, 64'd0);
        @(posedge CLK); #1;
        RST_N = 1'b1;
        issue_job(10'd1);
        push_exp(48'd200, 1'b0);
        send_pair(18'd20, 18'd10, D_GARB);
        in_valid = 1'b0;
        wait_drain();

        // Pre-adder job: (25+10)*20 = 700 when enabled, 10*20 = 200 otherwise
        issue_job(10'd1);
        push_exp(PRE_RES, 1'b0);
        send_pair(18'd20, 18'd10, 18'd25);
        in_valid = 1'b0;
        wait_drain();
        check("dsp_d_value", {46'd0, dsp_d}, {46'd0, LAST_D});

        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
